// File: rtl/acc_pkg.sv
// acc_pkg: op codes and flag bit positions shared by the accumulator bank and its ALU.
package acc_pkg;
   localparam logic [2:0] OP_HOLD = 3'd0;
   localparam logic [2:0] OP_LOAD = 3'd1;
   localparam logic [2:0] OP_ADD  = 3'd2;
   localparam logic [2:0] OP_SUB  = 3'd3;
   localparam logic [2:0] OP_INC  = 3'd4;
   localparam logic [2:0] OP_DEC  = 3'd5;
   localparam logic [2:0] OP_SHL  = 3'd6;
   localparam logic [2:0] OP_SHR  = 3'd7;
   localparam int FLAG_Z = 0;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 2;
   localparam int FLAG_N = 3;
endpackage

// File: rtl/acc_bank_if.sv
// acc_bank_if: control, write and read port bundle of the accumulator bank.
interface acc_bank_if #(
   parameter int WIDTH = 4,
   parameter int SEL_W = 1
);
   logic             clr_i;
   logic             en_i;
   logic [2:0]       op_i;
   logic [SEL_W-1:0] wr_sel_i;
   logic [WIDTH-1:0] data_i;
   logic [SEL_W-1:0] rd_sel_i;
   logic [WIDTH-1:0] acc_o;
   logic [3:0]       flags_o;
   modport master (output clr_i, en_i, op_i, wr_sel_i, data_i, rd_sel_i, input acc_o, flags_o);
   modport slave  (input clr_i, en_i, op_i, wr_sel_i, data_i, rd_sel_i, output acc_o, flags_o);
endinterface

// File: rtl/acc_alu.sv
// acc_alu: combinational accumulator op unit producing the new value and {N,V,C,Z}.
module acc_alu import acc_pkg::*; #(
   parameter int WIDTH    = 4,
   parameter int SATURATE = 0
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] d_i,
   input  logic [2:0]       op_i,
   output logic [WIDTH-1:0] res_o,
   output logic [3:0]       flags_o
);
   logic             is_sub, is_arith, ovf;
   logic [WIDTH-1:0] b, raw;
   logic [WIDTH:0]   sum;
   always_comb begin
      is_sub   = op_i == OP_SUB || op_i == OP_DEC;
      is_arith = op_i inside {OP_ADD, OP_SUB, OP_INC, OP_DEC};
      b        = (op_i == OP_INC || op_i == OP_DEC) ? WIDTH'(1) : d_i;
      // the extra top bit is carry for add and borrow for subtract
      sum      = is_sub ? {1'b0, a_i} - {1'b0, b} : {1'b0, a_i} + {1'b0, b};
      ovf      = (is_sub ? a_i[WIDTH-1] != b[WIDTH-1] : a_i[WIDTH-1] == b[WIDTH-1])
                 && sum[WIDTH-1] != a_i[WIDTH-1];
      raw      = op_i == OP_LOAD ? d_i :
                 op_i == OP_SHL  ? {a_i[WIDTH-2:0], 1'b0} :
                 op_i == OP_SHR  ? {1'b0, a_i[WIDTH-1:1]} :
                 is_arith        ? sum[WIDTH-1:0] : a_i;
      res_o    = (SATURATE != 0 && is_arith && sum[WIDTH]) ? (is_sub ? '0 : '1) : raw;
      flags_o[FLAG_Z] = res_o == '0;
      flags_o[FLAG_N] = res_o[WIDTH-1];
      flags_o[FLAG_V] = is_arith && ovf;
      flags_o[FLAG_C] = is_arith ? sum[WIDTH] :
                        op_i == OP_SHL ? a_i[WIDTH-1] :
                        op_i == OP_SHR ? a_i[0] : 1'b0;
   end
endmodule

// File: rtl/acc_bank.sv
// acc_bank: NUM_ACC accumulators with per-accumulator flags, one op per enabled cycle,
// and an independent combinational read port.
module acc_bank import acc_pkg::*; #(
   parameter int WIDTH    = 4,
   parameter int NUM_ACC  = 2,
   parameter int SATURATE = 0,
   parameter int SEL_W    = $clog2(NUM_ACC)
) (
   input logic       clk_i,
   input logic       rst_n_i,
   acc_bank_if.slave bus
);
   logic [NUM_ACC-1:0][WIDTH-1:0] acc_q, acc_d;
   logic [NUM_ACC-1:0][3:0]       flg_q, flg_d;
   logic [WIDTH-1:0]              a_sel, res;
   logic [3:0]                    res_flg;
   // index compare loops keep out-of-range selects from touching any entry
   always_comb begin
      a_sel       = '0;
      bus.acc_o   = '0;
      bus.flags_o = '0;
      for (int i = 0; i < NUM_ACC; i++) begin
         if (bus.wr_sel_i == SEL_W'(i)) a_sel = acc_q[i];
         if (bus.rd_sel_i == SEL_W'(i)) begin
            bus.acc_o   = acc_q[i];
            bus.flags_o = flg_q[i];
         end
      end
   end
   acc_alu #(.WIDTH(WIDTH), .SATURATE(SATURATE)) u_alu (
      .a_i     (a_sel),
      .d_i     (bus.data_i),
      .op_i    (bus.op_i),
      .res_o   (res),
      .flags_o (res_flg)
   );
   always_comb begin
      acc_d = acc_q;
      flg_d = flg_q;
      if (bus.clr_i) begin
         acc_d = '0;
         flg_d = '0;
      end else if (bus.en_i && bus.op_i != OP_HOLD) begin
         for (int i = 0; i < NUM_ACC; i++) begin
            if (bus.wr_sel_i == SEL_W'(i)) begin
               acc_d[i] = res;
               flg_d[i] = res_flg;
            end
         end
      end
   end
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         acc_q <= '0;
         flg_q <= '0;
      end else begin
         acc_q <= acc_d;
         flg_q <= flg_d;
      end
   end
endmodule

// File: doc/acc_bank.md
# acc_bank

Parametrised accumulator bank, the next-generation accumulator stage of the microprocessor datapath. It holds `NUM_ACC` accumulators of `WIDTH` bits, each with its own registered status flags. Each enabled cycle it executes one operation (load, arithmetic, shift) on one selected accumulator. Reads are independent of the write port, so the control unit can read one accumulator while it updates another.

## Interface
Parameters:
- `WIDTH`, 4: accumulator and data width in bits; legal range ≥ 2.
- `NUM_ACC`, 2: number of accumulators; legal range ≥ 2.
- `SATURATE`, 0: when 1, ADD/SUB/INC/DEC clamp to unsigned limits instead of wrapping.
- `SEL_W`, `$clog2(NUM_ACC)`: width of the select ports. It is derived and must not be overridden.

Ports:
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_n_i`  in  1  asynchronous, active-low reset.
- `clr_i`  in  1  synchronous clear of all accumulators and all flags.
- `en_i`  in  1  execute `op_i` on accumulator `wr_sel_i` this cycle.
- `op_i`  in  3  operation code (see Operation).
- `wr_sel_i`  in  SEL_W  target accumulator index.
- `data_i`  in  WIDTH  operand for LOAD/ADD/SUB.
- `rd_sel_i`  in  SEL_W  read index.
- `acc_o`  out  WIDTH  registered value of accumulator `rd_sel_i`; the read mux is combinational.
- `flags_o`  out  4  {N, V, C, Z} of accumulator `rd_sel_i`.

## Operation
Op codes:
- 000 HOLD: no change to value or flags.
- 001 LOAD: A ← D.
- 010 ADD: A ← A + D.
- 011 SUB: A ← A − D.
- 100 INC: A ← A + 1.
- 101 DEC: A ← A − 1.
- 110 SHL: logical shift left, 0 shifted in.
- 111 SHR: logical shift right, 0 shifted in.

Flags are updated together with the value on every executed op except HOLD:
- Z = 1 when the result (after any saturation) is 0.
- N = MSB of the result.
- C:
  - ADD/INC: carry out of the MSB.
  - SUB/DEC: borrow, i.e. A < operand.
  - SHL: the bit shifted out of the MSB.
  - SHR: the bit shifted out of the LSB.
  - LOAD: 0.
- V: two's-complement overflow for ADD/SUB/INC/DEC; 0 for LOAD and shifts.

Saturation (`SATURATE`=1):
- Carry on ADD/INC → result = all ones.
- Borrow on SUB/DEC → result = 0.
- C and V still report the unclamped event.

Arithmetic is computed at WIDTH+1 bits; the extra bit is the carry/borrow.

Conditions and priority:
- `wr_sel_i` ≥ NUM_ACC (non-power-of-2 depth): the write is ignored.
- `rd_sel_i` ≥ NUM_ACC: `acc_o` = 0 and `flags_o` = 0.
- Priority: `rst_n_i` low > `clr_i` > `en_i`. When `clr_i` and `en_i` are asserted in the same cycle, the clear wins and the op is discarded.

## Timing
- Reset: all accumulators = 0, all flags = 0. With `rd_sel_i` = 0, `acc_o` = 0 and `flags_o` = 4'b0000 immediately, with no clock required.
- Reset asserted mid-operation aborts the pending update. Deassertion is synchronised externally; the first edge with `rst_n_i` high may already execute an op.
- Write latency is 1 cycle. With `en_i` high at edge k, the result and flags are visible on `acc_o`/`flags_o` after edge k when `rd_sel_i` = `wr_sel_i`.
- Read during write to the same index returns the pre-edge value; there is no bypass.
- `acc_o` follows a `rd_sel_i` change combinationally, within the same cycle.
- `en_i` low, or `op_i` = HOLD, leaves all state unchanged. Back-to-back ops on one accumulator chain at 1 op per cycle.
- `clr_i` takes effect at the edge and applies to every accumulator regardless of `wr_sel_i`.

## Structure
- Shared package `acc_pkg` holds:
  - the op-code localparams (`OP_HOLD` … `OP_SHR`);
  - the flag bit indices (`FLAG_Z`=0, `FLAG_C`=1, `FLAG_V`=2, `FLAG_N`=3).
- Sub-module `acc_alu` is purely combinational. It is parametrised by WIDTH and SATURATE, takes A, D and op, and returns the result and 4 flags.
- `acc_bank` holds the register array, the flag array, the write decode and the read mux.

## Test plan
- Reset and load (WIDTH=4, NUM_ACC=2):
  - Assert `rst_n_i` low mid-cycle → `acc_o` = 0 and `flags_o` = 0 asynchronously.
  - Then LOAD 4'hA into acc1 → after one edge, with `rd_sel_i` = 1, `acc_o` = 4'hA and `flags_o` = {N=1, V=0, C=0, Z=0}.
- Wrap vs saturate:
  - acc0 = 4'hF, INC with SATURATE=0 → `acc_o` = 0, Z=1, C=1.
  - Same with SATURATE=1 → `acc_o` = 4'hF, C=1, Z=0.
- Signed overflow: acc0 = 4'h7, ADD 4'h1 → `acc_o` = 4'h8, V=1, N=1, C=0.
- Borrow: acc0 = 4'h3, SUB 4'h5:
  - wrap (SATURATE=0) → `acc_o` = 4'hE, C=1;
  - saturate (SATURATE=1) → `acc_o` = 0, Z=1.
- Shifts: acc1 = 4'b1001:
  - SHL → 4'b0010, C=1;
  - then SHR → 4'b0001, C=0.
- Independence and priority:
  - Write acc0 while reading acc1 → acc1 is unchanged.
  - Same-index read during write shows the old value until the edge.
  - `clr_i` and `en_i` with LOAD in the same cycle → all accumulators = 0, flags = 0.
